// File: rtl/sevenseg_scan.sv
// Four-digit common-anode seven-segment scanner with frame-boundary commit of
// digit codes, per-digit blanking and whole-display blink.
module sevenseg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] dp_in,
  input  logic       load,
  input  logic [3:0] blank,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blink_ctr_q, blink_ctr_d;
  logic             phase_q, phase_d;
  logic             pend_valid_q, pend_valid_d;
  // Codes packed {A,B,C,D} so that nibble k belongs to anode an[k].
  logic [15:0]      disp_code_q, disp_code_d;
  logic [15:0]      pend_code_q, pend_code_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             tc, wrap, dark;
  logic [1:0]       sel;
  logic [3:0]       code;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      4'd10:   s = 7'h2F;
      4'd11:   s = 7'h21;
      4'd12:   s = 7'h11;
      4'd13:   s = 7'h06;
      4'd14:   s = 7'h07;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    div_d        = div_q;
    idx_d        = idx_q;
    blink_ctr_d  = blink_ctr_q;
    phase_d      = phase_q;
    pend_valid_d = pend_valid_q;
    disp_code_d  = disp_code_q;
    pend_code_d  = pend_code_q;
    disp_dp_d    = disp_dp_q;
    pend_dp_d    = pend_dp_q;

    tc   = (div_q == DIV_MAX);
    wrap = tc && (idx_q == 2'd3);

    if (tc) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (wrap) begin
      if (blink_ctr_q == BLK_MAX) begin
        blink_ctr_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_ctr_d = blink_ctr_q + BLK_W'(1);
      end
    end

    // Display registers only change at a frame wrap, so a frame is never torn.
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_code_d = {A, B, C, D};
        disp_dp_d   = dp_in;
      end else if (pend_valid_q) begin
        disp_code_d = pend_code_q;
        disp_dp_d   = pend_dp_q;
      end
    end else if (load) begin
      pend_code_d  = {A, B, C, D};
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    sel  = ~idx_q;
    code = disp_code_q[{sel, 2'b00} +: 4];
    dark = blank[sel] | (blink & phase_q);

    an_d         = dark ? 4'hF : ~(4'b0001 << sel);
    seg_d        = dark ? 7'h7F : decode(code);
    dp_d         = dark ? 1'b1 : ~disp_dp_q[sel];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      blink_ctr_q  <= '0;
      phase_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      disp_code_q  <= 16'hFFFF;
      pend_code_q  <= 16'hFFFF;
      disp_dp_q    <= '0;
      pend_dp_q    <= '0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      blink_ctr_q  <= blink_ctr_d;
      phase_q      <= phase_d;
      pend_valid_q <= pend_valid_d;
      disp_code_q  <= disp_code_d;
      pend_code_q  <= pend_code_d;
      disp_dp_q    <= disp_dp_d;
      pend_dp_q    <= pend_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan at REFRESH_DIV=4, BLINK_FRAMES=2 (16-cycle frames).
module tb_sevenseg_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] A, B, C, D, dp_in, blank;
  logic       load, blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  int errors = 0;
  int checks = 0;

  logic [3:0] an_obs  [16];
  logic [6:0] seg_obs [16];
  logic       dp_obs  [16];
  logic       fd_obs  [16];

  sevenseg_scan #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D), .dp_in(dp_in),
    .load(load), .blank(blank), .blink(blink), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] scan_an(int slot);
    case (slot)
      0:       return 4'h7;
      1:       return 4'hB;
      2:       return 4'hD;
      default: return 4'hE;
    endcase
  endfunction

  // Bounded wait until a negedge where frame_done is high.
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
  endtask

  // Record one 16-cycle frame starting from a frame_done negedge; load is a one-cycle strobe.
  task automatic capture();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      an_obs[i] = an; seg_obs[i] = seg; dp_obs[i] = dp; fd_obs[i] = frame_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: an=%h seg=%h dp=%b fd=%b, required an=F seg=7F dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    wait_frame();
    capture();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_obs[i] !== scan_an(i / 4) || seg_obs[i] !== 7'h7F || fd_obs[i] !== (i == 15)) begin
        errors++;
        $display("FAIL scan[%0d]: an=%h seg=%h fd=%b, required an=%h seg=7F fd=%b",
                 i, an_obs[i], seg_obs[i], fd_obs[i], scan_an(i / 4), (i == 15));
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h2F, 7'h06, 7'h11, 7'h7F};
    A = 4'd10; B = 4'd13; C = 4'd12; D = 4'd15; load = 1'b1;
    capture();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seg_obs[i] !== 7'h7F) begin
        errors++;
        $display("FAIL load_mid_old[%0d]: seg=%h, required 7F", i, seg_obs[i]);
      end
    end
    capture();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seg_obs[i] !== exp_seg[i / 4] || an_obs[i] !== scan_an(i / 4)) begin
        errors++;
        $display("FAIL load_mid_new[%0d]: an=%h seg=%h, required an=%h seg=%h",
                 i, an_obs[i], seg_obs[i], scan_an(i / 4), exp_seg[i / 4]);
      end
    end
  endtask

  task automatic test_load_at_wrap();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    repeat (15) @(negedge clk);
    A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL load_wrap_align: frame_done=%b, required 1", frame_done);
    end
    capture();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seg_obs[i] !== exp_seg[i / 4]) begin
        errors++;
        $display("FAIL load_wrap[%0d]: seg=%h, required %h", i, seg_obs[i], exp_seg[i / 4]);
      end
    end
    // Two loads in one frame: A=5 then A=6; old 1 stays on screen this frame.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        checks++;
        if (seg !== 7'h79) begin
          errors++;
          $display("FAIL two_loads_old[%0d]: seg=%h, required 79", i, seg);
        end
      end
      if (i == 2)      begin A = 4'd5; load = 1'b1; end
      else if (i == 6) begin A = 4'd6; load = 1'b1; end
      else load = 1'b0;
    end
    capture();
    exp_seg[0] = 7'h02;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seg_obs[i] !== exp_seg[i / 4]) begin
        errors++;
        $display("FAIL two_loads_new[%0d]: seg=%h, required %h", i, seg_obs[i], exp_seg[i / 4]);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    exp_an  = '{4'h7, 4'hB, 4'hD, 4'hF};
    exp_seg = '{7'h00, 7'h00, 7'h00, 7'h7F};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    A = 4'd8; B = 4'd8; C = 4'd8; D = 4'd8; dp_in = 4'b0100; load = 1'b1;
    capture();
    blank = 4'b0001;
    capture();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_obs[i] !== exp_an[i / 4] || seg_obs[i] !== exp_seg[i / 4] || dp_obs[i] !== exp_dp[i / 4]) begin
        errors++;
        $display("FAIL blank[%0d]: an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                 i, an_obs[i], seg_obs[i], dp_obs[i], exp_an[i / 4], exp_seg[i / 4], exp_dp[i / 4]);
      end
    end
    blank = 4'b0000;
    dp_in = 4'b0000;
  endtask

  task automatic test_blink();
    int dark_cnt;
    bit exp_dark;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    blink = 1'b1;
    wait_frame();
    // Phase toggles on every second wrap: frames after the first frame_done go lit,dark,dark,lit,lit.
    for (int f = 0; f < 5; f++) begin
      capture();
      dark_cnt = 0;
      for (int i = 0; i < 16; i++) if (an_obs[i] === 4'hF) dark_cnt++;
      exp_dark = (f == 1 || f == 2);
      checks++;
      if (dark_cnt != (exp_dark ? 16 : 0)) begin
        errors++;
        $display("FAIL blink_frame[%0d]: dark slots=%0d, required %0d", f, dark_cnt, exp_dark ? 16 : 0);
      end
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) begin
        checks++;
        if (an !== 4'hF) begin
          errors++;
          $display("FAIL blink_dark: an=%h, required F", an);
        end
        blink = 1'b0;
      end
      if (i == 7) begin
        checks++;
        if (an !== 4'hB) begin
          errors++;
          $display("FAIL blink_release: an=%h, required B", an);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    wait_frame();
    repeat (3) @(negedge clk);
    A = 4'd1; dp_in = 4'b1000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: an=%h seg=%h dp=%b fd=%b, required an=F seg=7F dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_frame();
    for (int f = 0; f < 2; f++) begin
      capture();
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (seg_obs[i] !== 7'h7F || dp_obs[i] !== 1'b1 || an_obs[i] !== scan_an(i / 4)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL reset_discard[%0d]: %0d slots differ, required 0 (seg=7F dp=1)", f, bad);
      end
    end
  endtask

  initial begin
    reset = 1'b1; A = 4'hF; B = 4'hF; C = 4'hF; D = 4'hF;
    dp_in = '0; load = 1'b0; blank = '0; blink = 1'b0;
    test_reset();
    test_scan();
    test_load_midframe();
    test_load_at_wrap();
    test_blank();
    test_blink();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
